// File: rtl/dct_coef_sequencer.sv
// 8x8 2-D DCT sequencer: walks 64 coefficients x 64 pixels, MACs (pixel-128)*cos_term, emits each coefficient.
// Latency: 66 cycles per coefficient (64 issue + 1 flush + 1 output), 4224 cycles per block with no stalls.
// Backpressure: coefficient held stable on coef_valid until coef_ready; sequencing pauses while stalled.
module dct_coef_sequencer #(
    parameter int ACC_W     = 48,
    parameter int OUT_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [2:0]  k1,
    output logic [2:0]  k2,
    output logic [2:0]  n1,
    output logic [2:0]  n2,
    input  logic [31:0] cos_term,
    output logic [5:0]  pix_addr,
    input  logic [7:0]  pix_data,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [5:0]  coef_idx,
    output logic [31:0] coef_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int PROD_W = 41;  // 9-bit signed pixel offset x 32-bit signed cosine

    state_t                   state_q, state_d;
    logic        [5:0]        k_q, k_d;
    logic        [5:0]        n_q, n_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [31:0]       cos_q, cos_d;
    logic                     v_q, v_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     coef_valid_q, coef_valid_d;
    logic        [5:0]        coef_idx_q, coef_idx_d;
    logic        [31:0]       coef_data_q, coef_data_d;

    logic signed [8:0]        pix_ofs;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;

    // Level-shift the pixel returned for the previous issue and accumulate it against the matching cosine.
    always_comb begin
        pix_ofs = $signed({1'b0, pix_data}) - 9'sd128;
        prod    = PROD_W'(pix_ofs) * PROD_W'(cos_q);
        acc_sum = acc_q + (v_q ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : {ACC_W{1'b0}});
    end

    // Sequencer next-state: issue 64 positions, drain the last product, then hold the result until accepted.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        acc_d        = acc_q;
        cos_d        = cos_q;
        v_d          = v_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        coef_valid_d = coef_valid_q;
        coef_idx_d   = coef_idx_q;
        coef_data_d  = coef_data_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    k_d     = 6'd0;
                    n_d     = 6'd0;
                    acc_d   = '0;
                    v_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // The RAM returns pix_data for this address next cycle, alongside the captured cosine.
                cos_d = $signed(cos_term);
                v_d   = 1'b1;
                acc_d = acc_sum;
                n_d   = n_q + 6'd1;
                if (n_q == 6'd63) begin
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                // Final product for n=63 lands here; the output register sees the completed sum directly.
                acc_d        = acc_sum;
                v_d          = 1'b0;
                coef_valid_d = 1'b1;
                coef_idx_d   = k_q;
                coef_data_d  = 32'(acc_sum >>> OUT_SHIFT);
                state_d      = S_OUT;
            end

            S_OUT: begin
                if (coef_ready) begin
                    coef_valid_d = 1'b0;
                    k_d          = k_q + 6'd1;
                    if (k_q == 6'd63) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Clearing here is safe: the first product of the next coefficient lands a cycle later.
                        acc_d   = '0;
                        n_d     = 6'd0;
                        state_d = S_RUN;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset abandons any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= 6'd0;
            n_q          <= 6'd0;
            acc_q        <= '0;
            cos_q        <= '0;
            v_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_idx_q   <= 6'd0;
            coef_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            cos_q        <= cos_d;
            v_q          <= v_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            coef_valid_q <= coef_valid_d;
            coef_idx_q   <= coef_idx_d;
            coef_data_q  <= coef_data_d;
        end
    end

    // LUT and RAM addressing come straight from flops, so they only move on clock edges.
    assign k1         = k_q[5:3];
    assign k2         = k_q[2:0];
    assign n1         = n_q[5:3];
    assign n2         = n_q[2:0];
    assign pix_addr   = n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign coef_valid = coef_valid_q;
    assign coef_idx   = coef_idx_q;
    assign coef_data  = coef_data_q;

endmodule
